// File: rtl/w_mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// w_mem_access_sequencer
//
// Owns the shared weight memory of the PE array. It sequences read bursts
// for the compute engine (CNN or FC addressing) and arbitrates the single
// loader write stream against those bursts.
//
// Optional feature macro: W_MEM_CONCURRENT_WR_EN
//   undefined : the loader writes only in IDLE with no command offered
//               (exclusive access to the memory).
//   defined   : the loader is always ready; writes run in parallel with
//               BURST/DRAIN. Read-after-write ordering inside a burst is
//               left to software.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid may not depend on ready; ready may depend on valid.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   read-burst command handshake (ready only in IDLE)
//   cmd_mode/base/len     burst mode, first address, read count (0 = none)
//   stall                 consumer back-pressure, holds issue in BURST
//   rd_enable             memory read strobe
//   rd_addr_cnn/_fc       read address on the port selected by mode, else 0
//   mode                  latched burst mode
//   data_valid            rd_enable delayed by one cycle
//   burst_done            one-cycle pulse in DRAIN
//   ld_valid/ld_ready     loader write beat handshake
//   ld_fc/ld_addr/ld_data loader beat: target port, address, data
//   wr_enable_cnn/_fc     registered write strobes
//   wr_addr_cnn/_fc       registered write address, 0 when not enabled
//   wr_data_cnn/_fc       registered write data, 0 when not enabled
//   dbg_state             current FSM state (0 IDLE, 1 BURST, 2 DRAIN)
// ---------------------------------------------------------------------------
module w_mem_access_sequencer #(
    parameter int          ADDR_W   = 14,
    parameter int          DATA_W   = 32,
    parameter logic [2:0]  MODE_CNN = 3'd1
) (
    input  logic              clk,
    input  logic              reset,
    // read-burst command
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              stall,
    // memory read port
    output logic              rd_enable,
    output logic [ADDR_W-1:0] rd_addr_cnn,
    output logic [ADDR_W-1:0] rd_addr_fc,
    output logic [2:0]        mode,
    output logic              data_valid,
    output logic              burst_done,
    // loader write stream
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_fc,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    // memory write ports
    output logic              wr_enable_cnn,
    output logic              wr_enable_fc,
    output logic [ADDR_W-1:0] wr_addr_cnn,
    output logic [ADDR_W-1:0] wr_addr_fc,
    output logic [DATA_W-1:0] wr_data_cnn,
    output logic [DATA_W-1:0] wr_data_fc,
    // debug
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic [2:0]        mode_q,  mode_d;
    logic              data_valid_q;
    logic              rd_issue;
    logic              mode_is_cnn;

    logic              ld_accept;
    logic              wr_en_cnn_q, wr_en_fc_q;
    logic [ADDR_W-1:0] wr_addr_cnn_q, wr_addr_fc_q;
    logic [DATA_W-1:0] wr_data_cnn_q, wr_data_fc_q;

    // ------------------------------------------------------------------
    // Read sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            mode_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            data_valid_q <= rd_issue;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        rd_issue = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    addr_d  = cmd_base;
                    cnt_d   = cmd_len;
                    // A zero-length command still produces a done pulse.
                    state_d = (cmd_len == '0) ? S_DRAIN : S_BURST;
                end
            end
            S_BURST: begin
                if (!stall) begin
                    rd_issue = 1'b1;
                    addr_d   = addr_q + ONE;   // wraps modulo 2^ADDR_W
                    cnt_d    = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Last read's data returns here; stall has no effect.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mode_is_cnn = (mode_q == MODE_CNN);

    // reset gates the handshake readies so every output is 0 in reset.
    assign cmd_ready   = reset && (state_q == S_IDLE);
    assign rd_enable   = rd_issue;
    assign rd_addr_cnn = (rd_issue &&  mode_is_cnn) ? addr_q : '0;
    assign rd_addr_fc  = (rd_issue && !mode_is_cnn) ? addr_q : '0;
    assign mode        = mode_q;
    assign data_valid  = data_valid_q;
    assign burst_done  = (state_q == S_DRAIN);
    assign dbg_state   = state_q;

    // ------------------------------------------------------------------
    // Loader write path
    // ------------------------------------------------------------------
`ifdef W_MEM_CONCURRENT_WR_EN
    assign ld_ready = reset;
`else
    // A command offered in IDLE wins over a loader beat in the same cycle.
    assign ld_ready = reset && (state_q == S_IDLE) && !cmd_valid;
`endif

    assign ld_accept = ld_valid && ld_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_cnn_q   <= 1'b0;
            wr_en_fc_q    <= 1'b0;
            wr_addr_cnn_q <= '0;
            wr_addr_fc_q  <= '0;
            wr_data_cnn_q <= '0;
            wr_data_fc_q  <= '0;
        end else begin
            wr_en_cnn_q   <= ld_accept && !ld_fc;
            wr_en_fc_q    <= ld_accept &&  ld_fc;
            wr_addr_cnn_q <= (ld_accept && !ld_fc) ? ld_addr : '0;
            wr_addr_fc_q  <= (ld_accept &&  ld_fc) ? ld_addr : '0;
            wr_data_cnn_q <= (ld_accept && !ld_fc) ? ld_data : '0;
            wr_data_fc_q  <= (ld_accept &&  ld_fc) ? ld_data : '0;
        end
    end

    assign wr_enable_cnn = wr_en_cnn_q;
    assign wr_enable_fc  = wr_en_fc_q;
    assign wr_addr_cnn   = wr_addr_cnn_q;
    assign wr_addr_fc    = wr_addr_fc_q;
    assign wr_data_cnn   = wr_data_cnn_q;
    assign wr_data_fc    = wr_data_fc_q;

endmodule

// File: tb/tb_w_mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for w_mem_access_sequencer. Inputs are driven 1 ns after the rising
// edge, outputs are sampled on the falling edge. Cycle 0 is the cycle in
// which a command (or loader beat) is offered.
// ---------------------------------------------------------------------------
module tb_w_mem_access_sequencer;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int WQ_W   = 1 + ADDR_W + DATA_W;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_mode;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_len;
    logic              stall;
    logic              rd_enable;
    logic [ADDR_W-1:0] rd_addr_cnn;
    logic [ADDR_W-1:0] rd_addr_fc;
    logic [2:0]        mode;
    logic              data_valid;
    logic              burst_done;
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_fc;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              wr_enable_cnn;
    logic              wr_enable_fc;
    logic [ADDR_W-1:0] wr_addr_cnn;
    logic [ADDR_W-1:0] wr_addr_fc;
    logic [DATA_W-1:0] wr_data_cnn;
    logic [DATA_W-1:0] wr_data_fc;
    logic [1:0]        dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [ADDR_W-1:0] exp_q[$];     // expected read addresses, in order
    logic [WQ_W-1:0]   wr_exp_q[$];  // expected writes {fc, addr, data}

    w_mem_access_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MODE_CNN (3'd1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_base      (cmd_base),
        .cmd_len       (cmd_len),
        .stall         (stall),
        .rd_enable     (rd_enable),
        .rd_addr_cnn   (rd_addr_cnn),
        .rd_addr_fc    (rd_addr_fc),
        .mode          (mode),
        .data_valid    (data_valid),
        .burst_done    (burst_done),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_fc         (ld_fc),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .wr_enable_cnn (wr_enable_cnn),
        .wr_enable_fc  (wr_enable_fc),
        .wr_addr_cnn   (wr_addr_cnn),
        .wr_addr_fc    (wr_addr_fc),
        .wr_data_cnn   (wr_data_cnn),
        .wr_data_fc    (wr_data_fc),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- write scoreboard ----------------
    always @(negedge clk) begin
        logic [WQ_W-1:0] e;
        logic            e_fc;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        logic [93:0] act_v, exp_v;
        act_v = {wr_enable_cnn, wr_enable_fc, wr_addr_cnn, wr_addr_fc, wr_data_cnn, wr_data_fc};
        if (wr_enable_cnn || wr_enable_fc) begin
            if (wr_exp_q.size() == 0) begin
                check("wr_unexpected", {34'd0, act_v}, 128'd0);
            end else begin
                e = wr_exp_q.pop_front();
                {e_fc, e_addr, e_data} = e;
                exp_v = {!e_fc, e_fc,
                         e_fc ? '0 : e_addr, e_fc ? e_addr : '0,
                         e_fc ? '0 : e_data, e_fc ? e_data : '0};
                check("wr_beat", {34'd0, act_v}, {34'd0, exp_v});
            end
        end else begin
            check("wr_idle_zero", {34'd0, act_v}, 128'd0);
        end
    end

    // ---------------- burst vector table ----------------
    typedef struct {
        logic [2:0]        mode;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] len;
        logic [31:0]       stall_mask;  // bit c = stall in cycle c
        int                exp_done;    // burst_done cycle, -1 = derive
    } burst_vec_t;

    function automatic logic stall_at(input logic [31:0] sm, input int c);
        return (c < 32) ? sm[c] : 1'b0;
    endfunction

    task automatic run_burst(input burst_vec_t v);
        bit                en [0:63];
        int                issued;
        int                done_c;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] got;
        logic              is_cnn;
        for (int i = 0; i < 64; i++) en[i] = 1'b0;
        issued = 0;
        done_c = 1;
        // Expected issue pattern: one read per non-stalled BURST cycle.
        if (v.len != '0) begin
            for (int c = 1; c < 60; c++) begin
                if (!stall_at(v.stall_mask, c)) begin
                    en[c] = 1'b1;
                    issued++;
                    if (issued == int'(v.len)) begin
                        done_c = c + 1;
                        break;
                    end
                end
            end
        end
        if (v.exp_done >= 0) done_c = v.exp_done;
        is_cnn = (v.mode == 3'd1);
        a = v.base;
        for (int i = 0; i < int'(v.len); i++) begin
            exp_q.push_back(a);
            a = a + 14'd1;
        end

        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_mode  = v.mode;
        cmd_base  = v.base;
        cmd_len   = v.len;
        stall     = 1'b0;
        @(negedge clk);
        check("cmd_ready_c0", cmd_ready, 1);

        for (int c = 1; c <= done_c + 1; c++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            stall     = stall_at(v.stall_mask, c);
            @(negedge clk);
            check("rd_enable", rd_enable, en[c]);
            if (rd_enable) begin
                if (exp_q.size() == 0) begin
                    check("rd_extra", 1, 0);
                end else begin
                    got = is_cnn ? rd_addr_cnn : rd_addr_fc;
                    check("rd_addr", got, exp_q.pop_front());
                    check("rd_addr_other", is_cnn ? rd_addr_fc : rd_addr_cnn, 0);
                end
            end else begin
                check("rd_addr_idle", {rd_addr_cnn, rd_addr_fc}, 0);
            end
            check("data_valid", data_valid, en[c-1]);
            check("burst_done", burst_done, (c == done_c));
            check("cmd_ready", cmd_ready, (c == done_c + 1));
            if (c <= done_c) check("mode", mode, v.mode);
        end
        stall = 1'b0;
        check("rd_queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- loader stream ----------------
    task automatic ld_beat(input logic fc, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        @(posedge clk); #1;
        ld_valid = 1'b1;
        ld_fc    = fc;
        ld_addr  = addr;
        ld_data  = data;
        @(negedge clk);
        check("ld_ready_idle", ld_ready, 1);
        wr_exp_q.push_back({fc, addr, data});
    endtask

    task automatic ld_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ld_valid = 1'b0;
        end
    endtask

    // ---------------- collision ----------------
    task automatic run_collision();
        int l;
        l = 3;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_mode  = 3'd1;
        cmd_base  = 14'h0020;
        cmd_len   = 14'(l);
        ld_valid  = 1'b1;
        ld_fc     = 1'b0;
        ld_addr   = 14'd9;
        ld_data   = 32'h55AA1234;
        @(negedge clk);
        check("coll_cmd_ready", cmd_ready, 1);
`ifdef W_MEM_CONCURRENT_WR_EN
        check("coll_ld_ready_c0", ld_ready, 1);
        wr_exp_q.push_back({1'b0, 14'd9, 32'h55AA1234});
        for (int c = 1; c <= l + 2; c++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            ld_valid  = 1'b0;
            @(negedge clk);
            check("coll_ld_ready", ld_ready, 1);
        end
`else
        check("coll_ld_ready_c0", ld_ready, 0);
        for (int c = 1; c <= l + 2; c++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            check("coll_ld_ready", ld_ready, (c == l + 2));
            if (c == l + 2) wr_exp_q.push_back({1'b0, 14'd9, 32'h55AA1234});
        end
        @(posedge clk); #1;
        ld_valid = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("coll_wr_queue_empty", wr_exp_q.size(), 0);
    endtask

    // ---------------- reset mid-burst ----------------
    task automatic check_all_zero(input string name);
        check(name, {cmd_ready, ld_ready, rd_enable, rd_addr_cnn, rd_addr_fc, mode,
                     data_valid, burst_done, dbg_state}, 0);
    endtask

    task automatic run_reset_mid();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_mode  = 3'd2;
        cmd_base  = 14'h0040;
        cmd_len   = 14'd8;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_rd_c1", {rd_enable, rd_addr_fc}, {1'b1, 14'h0040});
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid_outputs_c2");
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("rst_mid_outputs_c3");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_done", {burst_done, rd_enable, data_valid}, 0);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        burst_vec_t vecs[8];
        burst_vec_t after_rst;

        vecs[0] = '{mode: 3'd1, base: 14'h0010, len: 14'd4, stall_mask: 32'h0,   exp_done: 5};
        vecs[1] = '{mode: 3'd2, base: 14'h3FFE, len: 14'd3, stall_mask: 32'h4,   exp_done: 5};
        vecs[2] = '{mode: 3'd1, base: 14'h0123, len: 14'd0, stall_mask: 32'h0,   exp_done: 1};
        vecs[3] = '{mode: 3'd0, base: 14'h0100, len: 14'd5, stall_mask: 32'h21A, exp_done: 9};
        vecs[4] = '{mode: 3'd1, base: 14'h3FFD, len: 14'd6, stall_mask: 32'h82,  exp_done: 9};
        for (int i = 5; i < 8; i++) begin
            vecs[i].mode       = 3'($urandom_range(0, 7));
            vecs[i].base       = 14'($urandom_range(0, 16383));
            vecs[i].len        = 14'($urandom_range(0, 6));
            vecs[i].stall_mask = 32'($urandom_range(0, 2047)) << 1;
            vecs[i].exp_done   = -1;
        end

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 3'd0;
        cmd_base  = '0;
        cmd_len   = '0;
        stall     = 1'b0;
        ld_valid  = 1'b0;
        ld_fc     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("reset_release_cmd_ready", cmd_ready, 1);
        check("reset_release_ld_ready", ld_ready, 1);

        for (int i = 0; i < 8; i++) run_burst(vecs[i]);

        // loader stream: three FC beats then CNN beats with a gap
        ld_beat(1'b1, 14'd5, 32'hA1B2C3D4);
        ld_beat(1'b1, 14'd6, 32'hA1B2C3D5);
        ld_beat(1'b1, 14'd7, 32'hA1B2C3D6);
        ld_idle(1);
        ld_beat(1'b0, 14'($urandom_range(0, 16383)), $urandom);
        ld_beat(1'b0, 14'h3FFF, 32'hFFFF_FFFF);
        ld_idle(3);
        check("ld_stream_drained", wr_exp_q.size(), 0);

        run_collision();

        run_reset_mid();
        after_rst = '{mode: 3'd2, base: 14'h0200, len: 14'd8, stall_mask: 32'h0, exp_done: 9};
        run_burst(after_rst);

        repeat (3) @(negedge clk);
        check("final_wr_queue_empty", wr_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Hard bound on simulation time in case a sequence stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/w_mem_access_sequencer.md
# w_mem_access_sequencer

Controller that owns the shared weight memory of the PE array. It sequences read bursts for the compute engine in CNN or FC mode and arbitrates the single loader write stream against those bursts. It drives the weight-memory wrapper's read and write ports, including rd_enable, rd_addr_cnn, rd_addr_fc, mode, wr_enable_cnn/fc, wr_addr_cnn/fc and wr_data_cnn/fc. It also tells the datapath when returned weight words are valid.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the weight memory (2^ADDR_W words).
- DATA_W, 32, loader write data width (4 weights × 8 bit).
- MODE_CNN, 1, mode encoding that selects CNN addressing; any other mode value is FC.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  read-burst command offered
- cmd_ready  out  1  sequencer accepts a command (high only in IDLE)
- cmd_mode  in  3  burst mode, latched at accept
- cmd_base  in  ADDR_W  first read address
- cmd_len  in  ADDR_W  number of reads; 0 means no reads
- stall  in  1  consumer back-pressure; suppresses issue this cycle
- rd_enable  out  1  memory read strobe
- rd_addr_cnn  out  ADDR_W  read address when mode==MODE_CNN, else 0
- rd_addr_fc  out  ADDR_W  read address when mode!=MODE_CNN, else 0
- mode  out  3  latched burst mode; stable from accept through DRAIN
- data_valid  out  1  memory read data valid this cycle (rd_enable delayed 1)
- burst_done  out  1  one-cycle pulse when the burst completes
- ld_valid  in  1  loader write beat offered
- ld_ready  out  1  loader beat accepted
- ld_fc  in  1  1 = FC write port, 0 = CNN write port
- ld_addr  in  ADDR_W  write address
- ld_data  in  DATA_W  write data
- wr_enable_cnn, wr_enable_fc  out  1  registered write strobes
- wr_addr_cnn, wr_addr_fc  out  ADDR_W  registered write address; 0 when not enabled
- wr_data_cnn, wr_data_fc  out  DATA_W  registered write data; 0 when not enabled

## Operation
- **States:** IDLE, BURST and DRAIN.
- **IDLE:**
  - cmd_ready=1.
  - cmd_valid with cmd_len≠0 latches mode, addr=cmd_base and cnt=cmd_len, then moves to BURST.
  - cmd_valid with cmd_len==0 is accepted, moves directly to DRAIN and issues no reads.
- **BURST:**
  - Each cycle with stall=0 asserts rd_enable, presents addr on the port selected by mode, increments addr (mod 2^ADDR_W, so 0x3FFF wraps to 0) and decrements cnt.
  - A cycle with stall=1 deasserts rd_enable and holds addr and cnt.
  - When the last read issues (cnt==1 and no stall), the state moves to DRAIN.
- **DRAIN (one cycle):**
  - rd_enable=0 and burst_done=1.
  - data_valid carries the last read in this cycle.
  - stall is ignored.
  - The state returns to IDLE.
- **data_valid:** registered copy of rd_enable. mode stays constant while any data_valid of the burst is outstanding.
- **Loader arbitration (macro undefined):**
  - ld_ready = (state==IDLE) && !cmd_valid. A command in the same cycle wins.
  - An accepted beat drives wr_enable_cnn or wr_enable_fc, per ld_fc, with addr and data in the next cycle. All other write outputs are 0.
- **Reset:** all outputs are 0, state=IDLE, cnt=0 and addr=0. Reset asserted mid-burst aborts the burst with no burst_done. After reset release, cmd_ready=1 from the first clock.

## Timing
- Command accepted at cycle 0, no stalls:
  - rd_enable is high in cycles 1..len with addresses base..base+len-1.
  - data_valid is high in cycles 2..len+1.
  - burst_done is high in cycle len+1.
  - cmd_ready returns at cycle len+2.
- Each stall cycle in BURST delays every later event by exactly one cycle.
- Loader write latency is 1 cycle, from ld_valid&ld_ready to wr_enable_*. Throughput is one beat per cycle while ld_ready is high.
- A zero-length command accepted at cycle 0 gives burst_done at cycle 1 and cmd_ready at cycle 2.

## Configuration
- **W_MEM_CONCURRENT_WR_EN defined:**
  - ld_ready=1 in every state, so loader writes proceed in parallel with BURST and DRAIN.
  - The write path is independent of the read sequencer.
  - Read-after-write ordering to the same address inside a burst is the software's responsibility.
- **Undefined:** the loader is blocked outside IDLE, and blocked in IDLE when cmd_valid=1 (exclusive access).

## Test plan
- **CNN burst:** mode=1, base=0x0010, len=4, no stall → rd_enable cycles 1–4 with rd_addr_cnn 0x10..0x13 and rd_addr_fc=0; data_valid cycles 2–5; burst_done at cycle 5.
- **FC burst with stall:** mode=2, base=0x3FFE, len=3, stall high in cycle 2 → rd_addr_fc 0x3FFE, (gap), 0x3FFF, 0x0000; burst_done at cycle 5.
- **Collision:** cmd_valid and ld_valid asserted together in IDLE → command accepted, ld_ready=0. Without the macro the loader waits until cycle len+2. With W_MEM_CONCURRENT_WR_EN the write appears at cycle 1.
- **Loader stream:** 3 FC beats, addr 5,6,7, data 0xA1B2C3D4.. → wr_enable_fc high cycles 1–3 with matching addr and data; wr_enable_cnn and the CNN write address/data stay 0.
- **Zero-length command:** cmd_len=0 → no rd_enable; burst_done at cycle 1.
- **Reset mid-operation:** reset low in cycle 2 of a len=8 burst → all outputs 0, no burst_done; a new command after release completes normally.
